// File: rtl/sound_pkg.sv
// Shared types and constants for the sound frame sequencer.
// Optional macro SOUND_FS_DIV_SYNC_EN switches the step source to the DIV timer.
package sound_pkg;

    typedef logic [2:0] step_t;

    localparam int    PRESCALE_DEFAULT = 8192;
    localparam step_t STEP_SWEEP_A     = 3'd2;
    localparam step_t STEP_SWEEP_B     = 3'd6;
    localparam step_t STEP_ENV         = 3'd7;

    // Length counters are clocked on every even step.
    function automatic logic is_length_step(input step_t s);
        return (s[0] == 1'b0);
    endfunction

    function automatic logic is_sweep_step(input step_t s);
        return (s == STEP_SWEEP_A) || (s == STEP_SWEEP_B);
    endfunction

endpackage

// File: rtl/sound_fs_tick.sv
// Step-event source for the frame sequencer: internal prescaler by default,
// or a falling-edge detector on div_bit when SOUND_FS_DIV_SYNC_EN is defined.
module sound_fs_tick
    import sound_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic sound_en,
`ifdef SOUND_FS_DIV_SYNC_EN
    input  logic div_bit,
`endif
    output logic step_evt
);

`ifdef SOUND_FS_DIV_SYNC_EN

    logic div_hist;

    // History keeps tracking while sound is off so re-enabling sees a clean edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_hist <= 1'b0;
        end else begin
            div_hist <= div_bit;
        end
    end

    assign step_evt = sound_en & div_hist & ~div_bit;

`else

    localparam int              PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] prescaler;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler <= '0;
        end else if (!sound_en) begin
            prescaler <= '0;
        end else if (prescaler == LAST) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // The wrap edge itself is the step event; sound_en gates it off.
    assign step_evt = sound_en && (prescaler == LAST);

`endif

endmodule

// File: rtl/sound_frame_seq.sv
// Frame sequencer: 8-step counter with length/sweep/envelope strobes and a
// half-rate frequency strobe. SOUND_FS_DIV_SYNC_EN selects DIV-synced stepping.
module sound_frame_seq
    import sound_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  sound_en,
`ifdef SOUND_FS_DIV_SYNC_EN
    input  logic  div_bit,
`endif
    output step_t step,
    output logic  tick_length,
    output logic  tick_sweep,
    output logic  tick_env,
    output logic  tick_freq
);

    logic step_evt_p0;
    logic freq_phase;

    sound_fs_tick #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .sound_en (sound_en),
`ifdef SOUND_FS_DIV_SYNC_EN
        .div_bit  (div_bit),
`endif
        .step_evt (step_evt_p0)
    );

    // Stage p0 -> outputs: strobes decode the step value before it advances.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step        <= '0;
            tick_length <= 1'b0;
            tick_sweep  <= 1'b0;
            tick_env    <= 1'b0;
            tick_freq   <= 1'b0;
            freq_phase  <= 1'b0;
        end else if (!sound_en) begin
            step        <= '0;
            tick_length <= 1'b0;
            tick_sweep  <= 1'b0;
            tick_env    <= 1'b0;
            tick_freq   <= 1'b0;
            freq_phase  <= 1'b0;
        end else begin
            freq_phase  <= ~freq_phase;
            tick_freq   <= freq_phase;
            tick_length <= step_evt_p0 && is_length_step(step);
            tick_sweep  <= step_evt_p0 && is_sweep_step(step);
            tick_env    <= step_evt_p0 && (step == STEP_ENV);
            if (step_evt_p0) begin
                step <= step + 3'd1;
            end
        end
    end

endmodule
